// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_ctrl_pkg
// Shared types and elaboration helpers for the sequential multiply controller.
//   state_t    : controller FSM states.
//   mul_tag_t  : operand tag {a, b, is_unsign}. The operand fields are sized to
//                MAX_W and zero-extended, so one struct serves any WIDTH <= MAX_W.
//   calc_niter : number of iterate cycles for a given width / bits-per-cycle.
//   cnt_width  : width of the iteration counter.
//   bpc_legal  : whether a BITS_PER_CYCLE value is supported (1, 2 or 4).
package mul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_W = 64;

  // One bit per supported BITS_PER_CYCLE value: bits 1, 2 and 4.
  localparam int LEGAL_BPC_MASK = 32'h0000_0016;

  typedef struct packed {
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic             is_unsign;
  } mul_tag_t;

  function automatic int calc_niter(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int cnt_width(input int niter);
    return (niter <= 2) ? 1 : $clog2(niter);
  endfunction

  function automatic bit bpc_legal(input int bpc);
    return (bpc >= 0) && (bpc < 32) && LEGAL_BPC_MASK[bpc];
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// mul_iter_core
// Shift-add datapath for an unsigned WIDTH x WIDTH -> 2*WIDTH multiply.
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset.
//   load           : capture operand magnitudes and clear the accumulator.
//   step           : retire BITS_PER_CYCLE multiplier bits into the accumulator.
//   negate         : replace the accumulator with its two's-complement negation.
//   a_mag, b_mag   : unsigned multiplicand / multiplier magnitudes.
//   acc            : accumulator (the product once all steps are done).
module mul_iter_core
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               negate,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] step_sum;
  logic [2*WIDTH-1:0] pp [BITS_PER_CYCLE];

  // Partial product for each multiplier bit retired this cycle.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
  end

  always_comb begin
    step_sum = acc_reg;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      step_sum = step_sum + pp[k];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (load) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
      mplier_reg <= b_mag;
      acc_reg    <= '0;
    end else if (step) begin
      acc_reg    <= step_sum;
      mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
      mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
    end else if (negate) begin
      acc_reg    <= -acc_reg;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequencing controller for a multi-cycle signed/unsigned multiply with a
// one-entry operand/result cache.
// Ports:
//   sys_clk, rst_n  : clock, asynchronous active-low reset.
//   req             : multiply requested this cycle.
//   is_unsign       : 1 = unsigned product, 0 = signed.
//   a, b            : multiplicand, multiplier.
//   flush           : kill; aborts any operation in flight.
//   result          : product while done=1, else 0.
//   done            : product for the current request is on result.
//   stall           : req && !done.
//   busy            : FSM is not in IDLE.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               is_unsign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               stall,
  output logic               busy
);

  localparam int NITER = calc_niter(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(NITER);

  if (!bpc_legal(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("mul_seq_ctrl: unsupported WIDTH/BITS_PER_CYCLE combination");
  end

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  mul_tag_t           tag_reg;
  logic               neg_reg;
  logic               cache_valid_reg;
  mul_tag_t           cache_tag_reg;
  logic [2*WIDTH-1:0] cache_prod_reg;

  mul_tag_t           cur_tag;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               live;
  logic               hit;
  logic               idle_hit;
  logic               done_match;
  logic               core_load;
  logic               core_step;
  logic               core_negate;

  always_comb begin
    cur_tag           = '0;
    cur_tag.a         = MAX_W'(a);
    cur_tag.b         = MAX_W'(b);
    cur_tag.is_unsign = is_unsign;
  end

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  assign a_mag = (!is_unsign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!is_unsign && b[WIDTH-1]) ? -b : b;

  // A request only counts when flush is low; flush also masks cache hits.
  assign live       = req && !flush;
  assign hit        = CACHE_EN && cache_valid_reg && (cur_tag == cache_tag_reg);
  assign idle_hit   = (state_reg == IDLE) && live && hit;
  // Operands may have changed while iterating; only deliver if they still match.
  assign done_match = (state_reg == DONE) && live && (cur_tag == tag_reg);

  assign core_load   = (state_reg == IDLE) && live && !hit;
  assign core_step   = (state_reg == RUN) && live;
  assign core_negate = (state_reg == SIGN) && live && neg_reg;

  mul_iter_core #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .load    (core_load),
    .step    (core_step),
    .negate  (core_negate),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .acc     (acc)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      tag_reg         <= '0;
      neg_reg         <= 1'b0;
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core_load) begin
            tag_reg   <= cur_tag;
            neg_reg   <= !is_unsign && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!live) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(NITER - 1)) begin
              state_reg <= SIGN;
            end
          end
        end
        SIGN: begin
          state_reg <= live ? DONE : IDLE;
        end
        DONE: begin
          state_reg <= IDLE;
          if (done_match) begin
            cache_valid_reg <= 1'b1;
            cache_tag_reg   <= tag_reg;
            cache_prod_reg  <= acc;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done   = idle_hit || done_match;
  assign result = done_match ? acc : (idle_hit ? cache_prod_reg : '0);
  assign stall  = req && !done;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
// Scoreboard bench for mul_seq_ctrl: expected products are queued when a
// request is driven and popped when done is observed.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic           sys_clk   = 1'b0;
  logic           rst_n     = 1'b0;
  logic           req       = 1'b0;
  logic           is_unsign = 1'b0;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;
  logic           flush     = 1'b0;
  logic [2*W-1:0] result;
  logic           done;
  logic           stall;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  mul_seq_ctrl #(
    .WIDTH          (W),
    .BITS_PER_CYCLE (2),
    .CACHE_EN       (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .req       (req),
    .is_unsign (is_unsign),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .result    (result),
    .done      (done),
    .stall     (stall),
    .busy      (busy)
  );

  // Reference product computed directly from the operands.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic u);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (u) return {32'b0, x} * {32'b0, y};
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction

  // Holds req high from the next cycle until done (or budget expiry).
  // Cycle 0 is the first cycle req is seen. Returns at the negedge of the
  // done cycle with req still asserted.
  task automatic run_req(input logic [31:0] x, input logic [31:0] y, input logic u,
                         output bit got, output int lat, output logic [63:0] res,
                         output int stall_bad);
    @(posedge sys_clk); #1;
    a = x; b = y; is_unsign = u; req = 1'b1; flush = 1'b0;
    got = 1'b0; lat = -1; res = '0; stall_bad = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge sys_clk);
      if (stall !== !done) stall_bad++;
      if (done === 1'b1) begin
        got = 1'b1; lat = cyc; res = result;
        break;
      end
      @(posedge sys_clk); #1;
    end
    $display("txn a=%h b=%h u=%0d done=%0d lat=%0d result=%h", x, y, u, got, lat, res);
  endtask

  task automatic go_idle(input int n);
    @(posedge sys_clk); #1;
    req = 1'b0; flush = 1'b0;
    repeat (n) @(posedge sys_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic test_unsigned_miss();
    bit got; int lat; logic [63:0] res; int sb;
    exp_q.push_back(64'hFFFFFFFE_00000001);
    run_req(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, got, lat, res, sb);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL unsigned_latency got=%0d exp=18", lat); end
    checks++; if (res !== exp_q.pop_front()) begin errors++; $display("FAIL unsigned_result got=%h exp=FFFFFFFE00000001", res); end
    checks++; if (sb != 0) begin errors++; $display("FAIL unsigned_stall bad_cycles=%0d exp=0", sb); end
    go_idle(2);
  endtask

  task automatic test_signed();
    bit got; int lat; logic [63:0] res; int sb; logic [63:0] e;
    exp_q.push_back(64'h40000000_00000000);
    run_req(32'h80000000, 32'h80000000, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL signed_edge_latency got=%0d exp=18", lat); end
    checks++; if (res !== e) begin errors++; $display("FAIL signed_edge_result got=%h exp=%h", res, e); end
    go_idle(1);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFE);
    run_req(32'hFFFFFFFF, 32'h00000002, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || res !== e) begin errors++; $display("FAIL signed_mixed_result got=%h exp=%h", res, e); end
    go_idle(1);
    exp_q.push_back(model(32'h00001234, 32'h80000000, 1'b0));
    run_req(32'h00001234, 32'h80000000, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || res !== e) begin errors++; $display("FAIL signed_posneg_result got=%h exp=%h", res, e); end
    go_idle(1);
  endtask

  task automatic test_cache_hit();
    bit got; int lat; logic [63:0] res; int sb; logic [63:0] e;
    exp_q.push_back(64'd42);
    run_req(32'd7, 32'd6, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL hit_fill got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    exp_q.push_back(64'd42);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    e = exp_q.pop_front();
    $display("txn a=%h b=%h u=%0d done=%0d lat=0 result=%h", a, b, is_unsign, done, result);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hit_done got=%b exp=1", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall got=%b exp=0", stall); end
    checks++; if (result !== e) begin errors++; $display("FAIL hit_result got=%h exp=%h", result, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_busy got=%b exp=0", busy); end
    exp_q.push_back(model(32'd7, 32'd6, 1'b1));
    run_req(32'd7, 32'd6, 1'b1, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL hit_unsign_flip got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    bit got; int lat; logic [63:0] res; int sb; logic [63:0] e;
    exp_q.push_back(model(32'd11, 32'd13, 1'b0));
    run_req(32'd11, 32'd13, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL b2b_first got=%h lat=%0d exp=%h", res, lat, e); end
    exp_q.push_back(model(32'hDEADBEEF, 32'h12345678, 1'b0));
    run_req(32'hDEADBEEF, 32'h12345678, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL b2b_new_miss got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    exp_q.push_back(model(32'd11, 32'd13, 1'b0));
    run_req(32'd11, 32'd13, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL b2b_evicted got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    exp_q.push_back(model(32'd11, 32'd13, 1'b0));
    run_req(32'd11, 32'd13, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 0 || res !== e || sb != 0) begin errors++; $display("FAIL b2b_hit got=%h lat=%0d exp=%h lat=0", res, lat, e); end
    go_idle(1);
  endtask

  task automatic test_mid_change();
    int first = -1; logic [63:0] res = '0; logic [63:0] e;
    exp_q.push_back(model(32'd12, 32'd11, 1'b1));
    @(posedge sys_clk); #1;
    a = 32'd10; b = 32'd11; is_unsign = 1'b1; req = 1'b1; flush = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 5) a = 32'd12;
      @(negedge sys_clk);
      if (done === 1'b1) begin first = cyc; res = result; break; end
      @(posedge sys_clk); #1;
    end
    e = exp_q.pop_front();
    $display("txn a=%h b=%h u=1 changed mid-run lat=%0d result=%h", a, b, first, res);
    checks++; if (first != 37) begin errors++; $display("FAIL midchange_latency got=%0d exp=37", first); end
    checks++; if (res !== e) begin errors++; $display("FAIL midchange_result got=%h exp=%h", res, e); end
    go_idle(1);
  endtask

  task automatic test_abort();
    bit got; int lat; logic [63:0] res; int sb; logic [63:0] e;
    bit saw_done = 1'b0; logic busy4 = 1'b0;
    @(posedge sys_clk); #1;
    a = 32'd3; b = 32'd5; is_unsign = 1'b0; req = 1'b1; flush = 1'b0;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc == 5) flush = 1'b1;
      @(negedge sys_clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (cyc == 4) busy4 = busy;
      @(posedge sys_clk); #1;
    end
    req = 1'b0; flush = 1'b0;
    @(negedge sys_clk);
    $display("txn a=%h b=%h u=0 flushed in cycle 5", 32'd3, 32'd5);
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL abort_busy_run got=%b exp=1", busy4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_cycle6 got=%b exp=0", busy); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", saw_done); end
    repeat (3) @(negedge sys_clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b done=%b exp=0,0", busy, done); end
    exp_q.push_back(64'd15);
    run_req(32'd3, 32'd5, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL abort_rerequest got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    go_idle(1);
  endtask

  task automatic test_reset_mid_run();
    bit got; int lat; logic [63:0] res; int sb; logic [63:0] e;
    logic busy8 = 1'b0;
    @(posedge sys_clk); #1;
    a = 32'h12345678; b = 32'h9ABCDEF0; is_unsign = 1'b1; req = 1'b1; flush = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 8) busy8 = busy;
      @(posedge sys_clk); #1;
    end
    rst_n = 1'b0;
    #1;
    $display("txn a=%h b=%h u=1 reset in cycle 9", a, b);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL rstrun_busy_before got=%b exp=1", busy8); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || result !== 64'h0) begin errors++; $display("FAIL rstrun_out done=%b result=%h exp=0,0", done, result); end
    req = 1'b0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(posedge sys_clk);
    exp_q.push_back(64'd15);
    run_req(32'd3, 32'd5, 1'b0, got, lat, res, sb);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 18 || res !== e) begin errors++; $display("FAIL rstrun_cache_cleared got=%h lat=%0d exp=%h lat=18", res, lat, e); end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_unsigned_miss();
    test_signed();
    test_cache_hit();
    test_back_to_back();
    test_mid_change();
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
